// File: rtl/perf_stat_unit_pkg.sv
// Shared types and constants for the performance statistics unit.
// Holds the FSM state encoding, the read-select for the cycle counter and the max-count helper.
package perf_stat_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } state_t;

  localparam logic [4:0] SEL_CYCLE = 5'd0;
  localparam int         CNT_W_MAX = 48;

  // All-ones value of a w-bit counter, right-aligned in the widest supported counter
  function automatic logic [CNT_W_MAX-1:0] max_count(input int w);
    return {CNT_W_MAX{1'b1}} >> (CNT_W_MAX - w);
  endfunction

endpackage

// File: rtl/perf_stat_unit_if.sv
// Control/status bundle of perf_stat_unit: event strobes, control and the counter read port.
// The master side (cpu glue or bench) drives the _i signals; the unit drives the _o signals.
interface perf_stat_unit_if #(
  parameter int NUM_EVENTS = 6,
  parameter int CNT_W      = 32
);
  logic                  enable_i;
  logic [NUM_EVENTS-1:0] event_i;
  logic                  halt_i;
  logic                  clear_i;
  logic [4:0]            rd_sel_i;
  logic [CNT_W-1:0]      rd_val_o;
  logic [CNT_W-1:0]      cycle_cnt_o;
  logic [NUM_EVENTS:0]   overflow_o;
  logic                  done_o;
  logic                  timeout_o;

  modport master (
    output enable_i, event_i, halt_i, clear_i, rd_sel_i,
    input  rd_val_o, cycle_cnt_o, overflow_o, done_o, timeout_o
  );

  modport slave (
    input  enable_i, event_i, halt_i, clear_i, rd_sel_i,
    output rd_val_o, cycle_cnt_o, overflow_o, done_o, timeout_o
  );
endinterface

// File: rtl/perf_stat_unit_counter.sv
// Single statistics counter with sticky overflow flag.
// On an increment at all-ones it either holds (SATURATE=1) or wraps to zero; both set overflow.
module perf_counter
  import perf_stat_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(max_count(CNT_W));

  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (inc) begin
      if (cnt_reg == MAX_CNT) begin
        ovf_reg <= 1'b1;
        cnt_reg <= SATURATE ? MAX_CNT : '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign cnt_o = cnt_reg;
  assign ovf_o = ovf_reg;

endmodule

// File: rtl/perf_stat_unit.sv
// Cycle and event statistics with halt freeze, watchdog and registered read port.
// Counter index 0 is the cycle counter; index k (1..NUM_EVENTS) is event channel k-1.
module perf_stat_unit
  import perf_stat_pkg::*;
#(
  parameter int     NUM_EVENTS  = 6,
  parameter int     CNT_W       = 32,
  parameter bit     SATURATE    = 1'b1,
  parameter longint CYCLE_LIMIT = 100000
) (
  input logic               clk,
  input logic               rst,
  perf_stat_unit_if.slave   bus
);

  state_t state_reg, state_next;

  logic [CNT_W-1:0]    cnt [NUM_EVENTS+1];
  logic [NUM_EVENTS:0] ovf;
  logic [NUM_EVENTS:0] inc;
  logic                count_en;
  logic                wd_hit;
  logic [CNT_W-1:0]    rd_val_reg, rd_val_next;

  assign count_en = (state_reg == RUN) && bus.enable_i;

  // Compare the post-increment cycle count in 64 bits so narrow counters never alias the limit
  assign wd_hit = (CYCLE_LIMIT != 0) && count_en &&
                  ((64'(cnt[0]) + 64'd1) > 64'(CYCLE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (bus.clear_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (bus.enable_i) state_next = RUN;
        RUN: begin
          if (bus.halt_i)  state_next = HALTED;
          else if (wd_hit) state_next = TIMEOUT;
        end
        default: state_next = state_reg;
      endcase
    end
  end

  for (genvar gi = 0; gi <= NUM_EVENTS; gi++) begin : g_cnt
    if (gi == 0) begin : g_cycle
      assign inc[gi] = count_en;
    end else begin : g_event
      assign inc[gi] = count_en & bus.event_i[gi-1];
    end

    perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (bus.clear_i),
      .inc   (inc[gi]),
      .cnt_o (cnt[gi]),
      .ovf_o (ovf[gi])
    );
  end

  always_comb begin
    rd_val_next = '0;
    if (bus.rd_sel_i == SEL_CYCLE) begin
      rd_val_next = cnt[0];
    end
    for (int i = 1; i <= NUM_EVENTS; i++) begin
      if (bus.rd_sel_i == 5'(i)) rd_val_next = cnt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_val_reg <= '0;
    end else begin
      rd_val_reg <= rd_val_next;
    end
  end

  assign bus.rd_val_o    = rd_val_reg;
  assign bus.cycle_cnt_o = cnt[0];
  assign bus.overflow_o  = ovf;
  assign bus.done_o      = (state_reg == HALTED);
  assign bus.timeout_o   = (state_reg == TIMEOUT);

endmodule

// File: tb/tb_perf_stat_unit.sv
// Directed bench for perf_stat_unit: four instances cover default, saturating, wrapping and watchdog setups.
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
module tb_perf_stat_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  perf_stat_unit_if #(.NUM_EVENTS(6), .CNT_W(32)) m_if ();
  perf_stat_unit_if #(.NUM_EVENTS(6), .CNT_W(8))  s_if ();
  perf_stat_unit_if #(.NUM_EVENTS(6), .CNT_W(8))  w_if ();
  perf_stat_unit_if #(.NUM_EVENTS(6), .CNT_W(32)) d_if ();

  perf_stat_unit #(.NUM_EVENTS(6), .CNT_W(32), .SATURATE(1'b1), .CYCLE_LIMIT(100000))
    u_main (.clk(clk), .rst(rst), .bus(m_if));
  perf_stat_unit #(.NUM_EVENTS(6), .CNT_W(8), .SATURATE(1'b1), .CYCLE_LIMIT(100000))
    u_sat (.clk(clk), .rst(rst), .bus(s_if));
  perf_stat_unit #(.NUM_EVENTS(6), .CNT_W(8), .SATURATE(1'b0), .CYCLE_LIMIT(100000))
    u_wrap (.clk(clk), .rst(rst), .bus(w_if));
  perf_stat_unit #(.NUM_EVENTS(6), .CNT_W(32), .SATURATE(1'b1), .CYCLE_LIMIT(20))
    u_wd (.clk(clk), .rst(rst), .bus(d_if));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    m_if.enable_i = 0; m_if.event_i = '0; m_if.halt_i = 0; m_if.clear_i = 0; m_if.rd_sel_i = '0;
    s_if.enable_i = 0; s_if.event_i = '0; s_if.halt_i = 0; s_if.clear_i = 0; s_if.rd_sel_i = '0;
    w_if.enable_i = 0; w_if.event_i = '0; w_if.halt_i = 0; w_if.clear_i = 0; w_if.rd_sel_i = '0;
    d_if.enable_i = 0; d_if.event_i = '0; d_if.halt_i = 0; d_if.clear_i = 0; d_if.rd_sel_i = '0;

    // Reset and enable
    tick(); tick();
    check("rst_cycle", m_if.cycle_cnt_o, 0);
    check("rst_rdval", m_if.rd_val_o, 0);
    check("rst_done", m_if.done_o, 0);
    check("rst_timeout", m_if.timeout_o, 0);
    check("rst_ovf", m_if.overflow_o, 0);
    rst = 1'b0;
    m_if.enable_i = 1; m_if.event_i = 6'b000001;
    repeat (11) tick();
    $display("run10: cycle=%0d", m_if.cycle_cnt_o);
    check("run10_cycle", m_if.cycle_cnt_o, 10);
    m_if.enable_i = 0; m_if.event_i = '0; m_if.rd_sel_i = 5'd1;
    tick();
    check("run10_ch0", m_if.rd_val_o, 10);
    m_if.rd_sel_i = 5'd2;
    tick();
    check("run10_ch1", m_if.rd_val_o, 0);
    check("pause_cycle", m_if.cycle_cnt_o, 10);

    // Halt freeze
    m_if.clear_i = 1; tick(); m_if.clear_i = 0;
    check("clr_cycle", m_if.cycle_cnt_o, 0);
    m_if.enable_i = 1; tick();
    for (int t = 1; t <= 5; t++) begin
      m_if.event_i = (t == 3 || t == 5) ? 6'b000100 : 6'b000000;
      m_if.halt_i  = (t == 5);
      tick();
    end
    m_if.halt_i = 0;
    $display("halt: cycle=%0d done=%0d", m_if.cycle_cnt_o, m_if.done_o);
    check("halt_cycle", m_if.cycle_cnt_o, 5);
    check("halt_done", m_if.done_o, 1);
    m_if.rd_sel_i = 5'd3; m_if.event_i = '1;
    tick();
    check("halt_ch2", m_if.rd_val_o, 2);
    repeat (4) tick();
    check("frozen_cycle", m_if.cycle_cnt_o, 5);
    check("frozen_ch2", m_if.rd_val_o, 2);
    m_if.event_i = '0;

    // Clear priority over halt and events
    m_if.clear_i = 1; tick(); m_if.clear_i = 0;
    tick();
    m_if.event_i = '1;
    repeat (3) tick();
    check("pre_clr_cycle", m_if.cycle_cnt_o, 3);
    m_if.clear_i = 1; m_if.halt_i = 1;
    tick();
    m_if.clear_i = 0; m_if.halt_i = 0; m_if.event_i = '0; m_if.rd_sel_i = 5'd1;
    $display("clear: cycle=%0d done=%0d", m_if.cycle_cnt_o, m_if.done_o);
    check("clrp_cycle", m_if.cycle_cnt_o, 0);
    check("clrp_ovf", m_if.overflow_o, 0);
    check("clrp_done", m_if.done_o, 0);
    tick();
    check("clrp_idle", m_if.cycle_cnt_o, 0);
    check("clrp_ch0", m_if.rd_val_o, 0);
    tick();
    check("clrp_resume", m_if.cycle_cnt_o, 1);

    // Read mux sweep: channel i gets i+1 events over 6 cycles
    m_if.clear_i = 1; tick(); m_if.clear_i = 0;
    tick();
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 6; i++) m_if.event_i[i] = (i >= t);
      tick();
    end
    m_if.enable_i = 0; m_if.event_i = '0;
    for (int sel = 0; sel <= 8; sel++) begin
      logic [63:0] exp_v;
      exp_v = (sel == 0) ? 64'd6 : (sel <= 6) ? 64'(sel) : 64'd0;
      m_if.rd_sel_i = 5'(sel);
      tick();
      $display("rd_sel=%0d rd_val=%0d", sel, m_if.rd_val_o);
      check($sformatf("mux_sel%0d", sel), m_if.rd_val_o, exp_v);
    end

    // Saturate and wrap with 8-bit counters
    s_if.enable_i = 1; s_if.event_i = 6'b000001;
    w_if.enable_i = 1; w_if.event_i = 6'b000001;
    tick();
    repeat (255) tick();
    check("sat255_cycle", s_if.cycle_cnt_o, 255);
    check("sat255_ovf", s_if.overflow_o, 0);
    check("wrap255_ovf", w_if.overflow_o, 0);
    tick();
    check("sat256_cycle", s_if.cycle_cnt_o, 255);
    check("wrap256_cycle", w_if.cycle_cnt_o, 0);
    repeat (44) tick();
    s_if.enable_i = 0; s_if.event_i = '0; s_if.rd_sel_i = 5'd1;
    w_if.enable_i = 0; w_if.event_i = '0; w_if.rd_sel_i = 5'd1;
    tick();
    $display("sat: ch0=%0d ovf=%b  wrap: ch0=%0d ovf=%b", s_if.rd_val_o, s_if.overflow_o,
             w_if.rd_val_o, w_if.overflow_o);
    check("sat_ch0", s_if.rd_val_o, 255);
    check("sat_ovf", s_if.overflow_o, 7'b0000011);
    check("wrap_ch0", w_if.rd_val_o, 44);
    check("wrap_cycle", w_if.cycle_cnt_o, 44);
    check("wrap_ovf", w_if.overflow_o, 7'b0000011);
    w_if.clear_i = 1; w_if.halt_i = 1; w_if.event_i = '1;
    tick();
    w_if.clear_i = 0; w_if.halt_i = 0; w_if.event_i = '0;
    check("wrap_clr_ovf", w_if.overflow_o, 0);
    check("wrap_clr_cycle", w_if.cycle_cnt_o, 0);

    // Watchdog with limit 20
    d_if.enable_i = 1;
    tick();
    repeat (20) tick();
    check("wd20_cycle", d_if.cycle_cnt_o, 20);
    check("wd20_timeout", d_if.timeout_o, 0);
    tick();
    $display("wd: cycle=%0d timeout=%0d done=%0d", d_if.cycle_cnt_o, d_if.timeout_o, d_if.done_o);
    check("wd21_timeout", d_if.timeout_o, 1);
    check("wd21_cycle", d_if.cycle_cnt_o, 21);
    check("wd21_done", d_if.done_o, 0);
    repeat (3) tick();
    check("wd_frozen", d_if.cycle_cnt_o, 21);
    d_if.clear_i = 1; tick(); d_if.clear_i = 0;
    check("wd_clr_timeout", d_if.timeout_o, 0);
    tick();
    repeat (20) tick();
    d_if.halt_i = 1;
    tick();
    d_if.halt_i = 0;
    $display("wd+halt: cycle=%0d timeout=%0d done=%0d", d_if.cycle_cnt_o, d_if.timeout_o, d_if.done_o);
    check("wdh_done", d_if.done_o, 1);
    check("wdh_timeout", d_if.timeout_o, 0);
    check("wdh_cycle", d_if.cycle_cnt_o, 21);
    tick();
    check("wdh_frozen", d_if.cycle_cnt_o, 21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_stat_unit.md
Name: perf_stat_unit

Overview:
Synthesizable, parametrised successor to the phase-3 bench statistics logic: counts cycles and N event channels (instruction retire, I/D cache hit, I/D cache request, ...) inside the cpu. Freezes all counts on halt, flags a watchdog timeout, and exposes counters through a registered read port. Sits beside the pipeline; event inputs come from WB/MEM-stage strobes and cache-controller strobes.

Parameters:
NUM_EVENTS, 6, number of event channels (1..16)
CNT_W, 32, width of every counter including the cycle counter (8..48)
SATURATE, 1, 1 = counters stick at all-ones; 0 = wrap to 0
CYCLE_LIMIT, 100000, watchdog limit on cycle count; 0 disables the watchdog

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
enable_i  in  1  counting permitted (tied to "out of reset" in the cpu)
event_i  in  NUM_EVENTS  per-channel event strobe, one count per cycle high
halt_i  in  1  halt reached the retire stage this cycle
clear_i  in  1  zero all counters and flags; return to IDLE
rd_sel_i  in  5  0 = cycle counter; 1..NUM_EVENTS = event channel rd_sel_i-1
rd_val_o  out  CNT_W  registered read data
cycle_cnt_o  out  CNT_W  live cycle counter
overflow_o  out  NUM_EVENTS+1  sticky per-counter overflow; bit 0 = cycle counter
done_o  out  1  halt captured, counters frozen
timeout_o  out  1  watchdog fired, counters frozen

Behaviour:
- Reset: all counters 0, overflow_o 0, rd_val_o 0, done_o 0, timeout_o 0, state IDLE.
- States:
  - IDLE -> RUN when enable_i=1.
  - RUN -> HALTED on halt_i.
  - RUN -> TIMEOUT when the cycle counter, after its increment, exceeds CYCLE_LIMIT and CYCLE_LIMIT != 0.
  - HALTED and TIMEOUT are absorbing until rst or clear_i.
- IDLE: nothing counts. Events are ignored even if enable_i rises in the same cycle; counting starts the cycle after IDLE->RUN.
- RUN, each cycle:
  - Cycle counter +1.
  - Each event channel +1 if its event_i bit is set.
  - enable_i low in RUN pauses all counting; it does not change state.
- Halt cycle: the cycle and events present with halt_i are counted. From the next edge, counts are frozen and done_o=1.
- halt_i and watchdog in the same cycle: HALTED wins, so timeout_o stays 0.
- Width:
  - SATURATE=1: a counter at 2^CNT_W-1 holds and sets its overflow bit when an increment is requested.
  - SATURATE=0: the counter wraps to 0 and sets the overflow bit.
  - Overflow bits are sticky until rst/clear_i.
- clear_i has priority over everything except rst. Next cycle: counters and flags are 0 and state is IDLE, regardless of halt_i or event_i that cycle. clear_i mid-RUN is legal.
- Read port: rd_val_o <= value selected by rd_sel_i, one-cycle latency. It reflects counter state before the same edge's update. rd_sel_i > NUM_EVENTS returns 0. The port stays readable in every state.
- Inputs in HALTED/TIMEOUT are ignored except rst, clear_i and rd_sel_i.

Decomposition:
- Package perf_stat_pkg holds:
  - state enum {IDLE, RUN, HALTED, TIMEOUT};
  - read-select constant SEL_CYCLE=0;
  - localparam for the max count expression.
- Sub-module perf_counter (params CNT_W, SATURATE; ports clk, rst, clr, inc, cnt_o, ovf_o) is instantiated NUM_EVENTS+1 times with a generate loop. The parent holds the FSM, watchdog compare and read mux.

Test Plan:
1. Reset/enable: rst 2 cycles, enable_i=1, 10 RUN cycles with event_i[0] high every cycle -> cycle_cnt_o=10, channel 0=10, others 0; rd_sel_i=1 gives rd_val_o=10 one cycle later.
2. Halt freeze: 5 cycles, events on channel 2 in cycles 3 and 5 with halt_i in cycle 5 -> channel 2=2, cycle=5, done_o=1. Further events and cycles leave counts unchanged.
3. Saturate/wrap with CNT_W=8, channel 0 driven 300 cycles:
   - SATURATE=1 -> count 255, overflow_o[1]=1.
   - SATURATE=0 -> count 44, overflow_o[1]=1.
4. Watchdog with CYCLE_LIMIT=20 and no halt -> timeout_o=1 after the 21st RUN cycle; cycle_cnt_o frozen at 21, done_o=0. Separately, halt_i coincident with cycle 21 -> done_o=1, timeout_o=0.
5. Clear priority: clear_i asserted together with halt_i and all events -> next cycle all counters 0, overflow 0, done_o 0, state IDLE; counting resumes when enable_i=1.
6. Read mux: rd_sel_i sweep 0..NUM_EVENTS+2 -> correct values with 1-cycle latency; out-of-range selects return 0.
